div_clk_monitor: RTL

Period monitor for the divided-clock output of the odd clock divider. It samples `clk_divided` in the source `clk` domain and measures every period in `clk` cycles. It checks each period against the programmed ratio, declares lock after a run of good periods, and flags mismatched periods and lost edges. It sits directly downstream of the divider and feeds clock-health status to the control/status logic.

---
 rtl/div_clk_monitor.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/div_clk_monitor.sv
// Period monitor for the odd divider's output: measures each divided-clock period
// in source-clock cycles, tracks lock, and reports period mismatches and lost edges.
module div_clk_monitor #(
    parameter int CNT_W      = 8,
    parameter int LOCK_COUNT = 4,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] exp_ratio,
    input  logic             clr_err,
    input  logic             clk_divided,
    output logic             locked,
    output logic             period_valid,
    output logic [CNT_W-1:0] measured_period,
    output logic             period_err,
    output logic             timeout,
    output logic [ERR_W-1:0] err_count,
    output logic             cfg_err
);

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam logic [GOOD_W-1:0] LOCK_GOOD = GOOD_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        MEASURE,
        LOCKED
    } state_t;

    state_t            state;
    logic              div_p0;
    logic              div_p1;
    logic              div_p2;
    logic              rise;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W:0]    thr;
    logic              over;
    logic              match;
    logic [GOOD_W-1:0] good;
    logic [GOOD_W-1:0] good_inc;
    logic              run;
    logic              err_inc;

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [ERR_W-1:0] err_sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Stage p0/p1: two-flop synchronizer; stage p2: edge-detect history
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_p0 <= 1'b0;
            div_p1 <= 1'b0;
            div_p2 <= 1'b0;
        end else begin
            div_p0 <= clk_divided;
            div_p1 <= div_p0;
            div_p2 <= div_p1;
        end
    end

    assign rise     = div_p1 & ~div_p2;
    assign thr      = {exp_ratio, 1'b0};
    assign over     = {1'b0, cnt} >= thr;
    assign match    = (cnt == exp_ratio);
    assign good_inc = good + 1'b1;
    assign run      = en & ~cfg_err;
    assign err_inc  = run & (state == LOCKED) & (rise ? ~match : over);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= (exp_ratio < CNT_W'(2));
        end
    end

    // Cycles since the last detected rising edge; parked at zero while idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (state == IDLE) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= CNT_W'(1);
        end else begin
            cnt <= cnt_sat_inc(cnt);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            good            <= '0;
            locked          <= 1'b0;
            period_valid    <= 1'b0;
            measured_period <= '0;
            period_err      <= 1'b0;
            timeout         <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            period_err   <= 1'b0;
            timeout      <= 1'b0;
            if (!run) begin
                state  <= IDLE;
                locked <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state  <= ACQUIRE;
                        locked <= 1'b0;
                    end
                    ACQUIRE: begin
                        if (rise) begin
                            good  <= '0;
                            state <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        if (rise) begin
                            period_valid    <= 1'b1;
                            measured_period <= cnt;
                            if (match) begin
                                good <= good_inc;
                                if (good_inc == LOCK_GOOD) begin
                                    state  <= LOCKED;
                                    locked <= 1'b1;
                                end
                            end else begin
                                good <= '0;
                            end
                        end else if (over) begin
                            timeout <= 1'b1;
                            state   <= ACQUIRE;
                        end
                    end
                    LOCKED: begin
                        if (rise) begin
                            period_valid    <= 1'b1;
                            measured_period <= cnt;
                            if (!match) begin
                                period_err <= 1'b1;
                                good       <= '0;
                                state      <= MEASURE;
                                locked     <= 1'b0;
                            end
                        end else if (over) begin
                            timeout <= 1'b1;
                            state   <= ACQUIRE;
                            locked  <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Clear takes priority so a clear never loses to a same-cycle error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_count <= '0;
        end else if (clr_err) begin
            err_count <= '0;
        end else if (err_inc) begin
            err_count <= err_sat_inc(err_count);
        end
    end

endmodule
